lsu_bus_bridge: RTL and testbench

Converts the core LSU's single-cycle data-memory request into a valid/ready bus transaction with a separate response channel. Sits directly downstream of the core's load/store path, between the core data-memory port and the data bus/memory. It stalls the core until the access completes and returns read data, a completion strobe and an error flag. It also enforces a response timeout.

---
 rtl/lsu_bus_bridge_if.sv | 33 +++
 rtl/lsu_bus_bridge.sv | 192 +++++++++++++++++++
 tb/tb_lsu_bus_bridge.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/lsu_bus_bridge_if.sv
// -----------------------------------------------------------------------------
// lsu_bus_bridge_if
// Bus-side signal bundle of the LSU bus bridge: a valid/ready request channel
// and a separate response strobe channel, plus the sticky posted-write error.
//   master : the bridge (drives the request fields, receives the responses)
//   slave  : the data bus / memory
// Parameters: DATA_WIDTH (bits, multiple of 8), ADDR_WIDTH (bits).
// -----------------------------------------------------------------------------
interface lsu_bus_bridge_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) ();
    logic                      bus_req_valid_o;
    logic                      bus_req_ready_i;
    logic                      bus_we_o;
    logic [ADDR_WIDTH-1:0]     bus_addr_o;
    logic [DATA_WIDTH-1:0]     bus_wdata_o;
    logic [DATA_WIDTH/8-1:0]   bus_be_o;
    logic                      bus_rsp_valid_i;
    logic [DATA_WIDTH-1:0]     bus_rsp_rdata_i;
    logic                      bus_rsp_err_i;
    logic                      bus_werr_o;

    modport master (
        output bus_req_valid_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_be_o, bus_werr_o,
        input  bus_req_ready_i, bus_rsp_valid_i, bus_rsp_rdata_i, bus_rsp_err_i
    );

    modport slave (
        input  bus_req_valid_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_be_o, bus_werr_o,
        output bus_req_ready_i, bus_rsp_valid_i, bus_rsp_rdata_i, bus_rsp_err_i
    );
endinterface

// File: rtl/lsu_bus_bridge.sv
// -----------------------------------------------------------------------------
// lsu_bus_bridge
// Turns the core LSU's single-cycle data-memory request into one valid/ready
// bus transaction, stalls the core until the response (or a timeout) arrives,
// then pulses core_rvalid_o for one cycle with read data and an error flag.
//
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   core_req_i/we/addr/wdata/be : core request, held while core_stall_o=1
//   core_stall_o        : core must hold its request
//   core_rvalid_o       : one-cycle completion strobe
//   core_rdata_o/err_o  : load data / error, held until the next completion
//   bus (master)        : request channel, response channel, bus_werr_o
//
// Optional feature: define LSU_BRIDGE_POSTED_WRITE_EN to complete stores at
// bus acceptance and consume their response in the background; a failing
// posted write sets the sticky bus_werr_o. Without it bus_werr_o is 0.
// -----------------------------------------------------------------------------
module lsu_bus_bridge #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    core_req_i,
    input  logic                    core_we_i,
    input  logic [ADDR_WIDTH-1:0]   core_addr_i,
    input  logic [DATA_WIDTH-1:0]   core_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] core_be_i,
    output logic                    core_stall_o,
    output logic                    core_rvalid_o,
    output logic [DATA_WIDTH-1:0]   core_rdata_o,
    output logic                    core_err_o,
    lsu_bus_bridge_if.master        bus
);
    localparam int BE_WIDTH  = DATA_WIDTH / 8;
    localparam int CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = CNT_WIDTH'(TIMEOUT_CYCLES);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REQ      = 2'd1,
        ST_WAIT_RSP = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

    state_t                  state_r;
    state_t                  state_s;
    logic                    req_we_r;
    logic [ADDR_WIDTH-1:0]   req_addr_r;
    logic [DATA_WIDTH-1:0]   req_wdata_r;
    logic [BE_WIDTH-1:0]     req_be_r;
    logic [CNT_WIDTH-1:0]    cnt_r;
    logic [DATA_WIDTH-1:0]   rdata_r;
    logic                    err_r;
    logic                    stall_s;
    logic                    valid_s;
    logic                    timeout_s;
    logic                    req_fire_s;
    logic                    wpend_s;
    logic                    posted_store_s;

`ifdef LSU_BRIDGE_POSTED_WRITE_EN
    logic wpend_r;
    logic werr_r;

    assign wpend_s        = wpend_r;
    assign posted_store_s = req_we_r;
    assign bus.bus_werr_o = werr_r;

    // Posted-write bookkeeping: the write response may arrive in any state.
    always_ff @(posedge clk) begin
        if (rst) begin
            wpend_r <= 1'b0;
            werr_r  <= 1'b0;
        end else if (wpend_r && bus.bus_rsp_valid_i) begin
            wpend_r <= 1'b0;
            werr_r  <= werr_r | bus.bus_rsp_err_i;
        end else if (req_fire_s && req_we_r) begin
            wpend_r <= 1'b1;
        end
    end
`else
    assign wpend_s        = 1'b0;
    assign posted_store_s = 1'b0;
    assign bus.bus_werr_o = 1'b0;
`endif

    assign req_fire_s = valid_s & bus.bus_req_ready_i;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next state, stall and request-valid decode.
    always_comb begin
        state_s   = state_r;
        stall_s   = 1'b0;
        valid_s   = 1'b0;
        timeout_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (core_req_i) begin
                    stall_s = 1'b1;
                    state_s = ST_REQ;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                stall_s = 1'b1;
                // A new request waits with valid low while a posted write is open.
                valid_s = ~wpend_s;
                if (valid_s && bus.bus_req_ready_i) begin
                    state_s = posted_store_s ? ST_DONE : ST_WAIT_RSP;
                end else begin
                    state_s = ST_REQ;
                end
            end
            ST_WAIT_RSP: begin
                stall_s = 1'b1;
                // A response in the last allowed cycle beats the timeout.
                if (bus.bus_rsp_valid_i) begin
                    state_s = ST_DONE;
                end else if (cnt_r >= CNT_LAST) begin
                    timeout_s = 1'b1;
                    state_s   = ST_DONE;
                end else begin
                    state_s = ST_WAIT_RSP;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Request latch, timeout counter and completion data.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_we_r    <= 1'b0;
            req_addr_r  <= {ADDR_WIDTH{1'b0}};
            req_wdata_r <= {DATA_WIDTH{1'b0}};
            req_be_r    <= {BE_WIDTH{1'b0}};
            cnt_r       <= {CNT_WIDTH{1'b0}};
            rdata_r     <= {DATA_WIDTH{1'b0}};
            err_r       <= 1'b0;
        end else begin
            if (state_r == ST_IDLE && core_req_i) begin
                req_we_r    <= core_we_i;
                req_addr_r  <= core_addr_i;
                req_wdata_r <= core_wdata_i;
                req_be_r    <= core_be_i;
            end
            if (state_r == ST_REQ && req_fire_s) begin
                cnt_r <= {CNT_WIDTH{1'b0}};
            end else if (state_r == ST_WAIT_RSP && !bus.bus_rsp_valid_i && cnt_r != CNT_MAX) begin
                cnt_r <= cnt_r + CNT_WIDTH'(1);
            end
            if (state_r == ST_WAIT_RSP && bus.bus_rsp_valid_i) begin
                rdata_r <= req_we_r ? {DATA_WIDTH{1'b0}} : bus.bus_rsp_rdata_i;
                err_r   <= bus.bus_rsp_err_i;
            end else if (timeout_s) begin
                rdata_r <= {DATA_WIDTH{1'b0}};
                err_r   <= 1'b1;
            end else if (state_r == ST_REQ && req_fire_s && posted_store_s) begin
                rdata_r <= {DATA_WIDTH{1'b0}};
                err_r   <= 1'b0;
            end
        end
    end

    assign core_stall_o        = stall_s;
    assign core_rvalid_o       = (state_r == ST_DONE);
    assign core_rdata_o        = rdata_r;
    assign core_err_o          = err_r;
    assign bus.bus_req_valid_o = valid_s;
    assign bus.bus_we_o        = req_we_r;
    assign bus.bus_addr_o      = req_addr_r;
    assign bus.bus_wdata_o     = req_wdata_r;
    assign bus.bus_be_o        = req_be_r;
endmodule

// File: tb/tb_lsu_bus_bridge.sv
// -----------------------------------------------------------------------------
// tb_lsu_bus_bridge
// Transaction-level bench for lsu_bus_bridge (default build, TIMEOUT_CYCLES=4).
// Each transaction is described by its core request, the bus ready delay and
// the response delay; the expected completion cycle, data and error come from
// simple arithmetic on those numbers.
// -----------------------------------------------------------------------------
module tb_lsu_bus_bridge;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int T  = 4;

    logic          clk;
    logic          rst;
    logic          core_req_i;
    logic          core_we_i;
    logic [AW-1:0] core_addr_i;
    logic [DW-1:0] core_wdata_i;
    logic [3:0]    core_be_i;
    logic          core_stall_o;
    logic          core_rvalid_o;
    logic [DW-1:0] core_rdata_o;
    logic          core_err_o;

    int checks_cnt = 0;
    int errors_cnt = 0;

    lsu_bus_bridge_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_if ();

    lsu_bus_bridge #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(T)) dut (
        .clk          (clk),
        .rst          (rst),
        .core_req_i   (core_req_i),
        .core_we_i    (core_we_i),
        .core_addr_i  (core_addr_i),
        .core_wdata_i (core_wdata_i),
        .core_be_i    (core_be_i),
        .core_stall_o (core_stall_o),
        .core_rvalid_o(core_rvalid_o),
        .core_rdata_o (core_rdata_o),
        .core_err_o   (core_err_o),
        .bus          (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One transaction. Entered and left at a falling edge. Cycle 0 presents the
    // request; the bridge is expected to raise valid in cycle 1, the bus accepts
    // after rdelay valid cycles, and the response (if any) comes d cycles after
    // the first wait cycle.
    task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] be, input int rdelay, input bit has_rsp,
                           input int d, input logic [31:0] rsp_data, input logic rsp_err);
        int  a        = 1 + rdelay;
        bit  hit      = has_rsp && (d < T);
        int  exp_done = hit ? (a + 2 + d) : (a + 1 + T);
        logic [31:0] exp_rdata = hit ? (we ? 32'h0 : rsp_data) : 32'h0;
        logic        exp_err   = hit ? rsp_err : 1'b1;
        int  last     = a + T + 4;
        int  valid_cnt = 0;
        int  acc_cnt   = 0;
        int  stall_cnt = 0;
        int  rv_cnt    = 0;
        int  rv_cycle  = -1;
        bit  done_seen = 1'b0;
        core_we_i    = we;
        core_addr_i  = addr;
        core_wdata_i = wdata;
        core_be_i    = be;
        for (int k = 0; k <= last; k++) begin
            core_req_i = !done_seen;
            bus_if.bus_req_ready_i = (k >= a);
            bus_if.bus_rsp_valid_i = has_rsp && (k == a + 1 + d);
            bus_if.bus_rsp_rdata_i = bus_if.bus_rsp_valid_i ? rsp_data : $urandom;
            bus_if.bus_rsp_err_i   = bus_if.bus_rsp_valid_i ? rsp_err : 1'($urandom_range(0, 1));
            #1;
            if (bus_if.bus_req_valid_o) begin
                valid_cnt++;
                if (bus_if.bus_req_ready_i) acc_cnt++;
                check_val("bus_we",    bus_if.bus_we_o,    we);
                check_val("bus_addr",  bus_if.bus_addr_o,  addr);
                check_val("bus_wdata", bus_if.bus_wdata_o, wdata);
                check_val("bus_be",    bus_if.bus_be_o,    be);
            end
            if (core_stall_o) stall_cnt++;
            if (core_rvalid_o) begin
                rv_cnt++;
                rv_cycle = k;
                done_seen = 1'b1;
                check_val("rdata", core_rdata_o, exp_rdata);
                check_val("err",   core_err_o,   exp_err);
            end
            @(negedge clk);
        end
        check_val("rvalid_cnt",  rv_cnt,    1);
        check_val("done_cycle",  rv_cycle,  exp_done);
        check_val("stall_cnt",   stall_cnt, exp_done);
        check_val("accept_cnt",  acc_cnt,   1);
        check_val("valid_cnt",   valid_cnt, a);
        check_val("rdata_hold",  core_rdata_o, exp_rdata);
        check_val("err_hold",    core_err_o,   exp_err);
        check_val("werr",        bus_if.bus_werr_o, 1'b0);
        bus_if.bus_req_ready_i = 1'b0;
        bus_if.bus_rsp_valid_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst          = 1'b1;
        core_req_i   = 1'b0;
        core_we_i    = 1'b0;
        core_addr_i  = 32'h0;
        core_wdata_i = 32'h0;
        core_be_i    = 4'h0;
        bus_if.bus_req_ready_i = 1'b0;
        bus_if.bus_rsp_valid_i = 1'b0;
        bus_if.bus_rsp_rdata_i = 32'h0;
        bus_if.bus_rsp_err_i   = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check_val("rst_stall",  core_stall_o,  1'b0);
        check_val("rst_rvalid", core_rvalid_o, 1'b0);
        check_val("rst_rdata",  core_rdata_o,  32'h0);
        check_val("rst_err",    core_err_o,    1'b0);
        check_val("rst_valid",  bus_if.bus_req_valid_o, 1'b0);
        check_val("rst_we",     bus_if.bus_we_o,    1'b0);
        check_val("rst_addr",   bus_if.bus_addr_o,  32'h0);
        check_val("rst_wdata",  bus_if.bus_wdata_o, 32'h0);
        check_val("rst_be",     bus_if.bus_be_o,    4'h0);
        check_val("rst_werr",   bus_if.bus_werr_o,  1'b0);
        @(negedge clk);

        // Directed: minimum-latency load, stalled store, timeouts, errors.
        run_txn(1'b0, 32'h100, 32'h0, 4'hF, 0, 1'b1, 0,     32'hDEADBEEF, 1'b0);
        run_txn(1'b1, 32'h200, 32'h12345678, 4'b0011, 4, 1'b1, 0, 32'h5555AAAA, 1'b0);
        run_txn(1'b0, 32'h300, 32'h0, 4'hF, 0, 1'b0, 0,     32'h0,        1'b0);
        run_txn(1'b0, 32'h304, 32'h0, 4'hF, 1, 1'b1, T,     32'hCAFEF00D, 1'b0);
        run_txn(1'b0, 32'h308, 32'h0, 4'hF, 0, 1'b1, 1,     32'h0BADC0DE, 1'b1);
        run_txn(1'b0, 32'h30C, 32'h0, 4'hF, 0, 1'b1, 0,     32'h01234567, 1'b0);
        run_txn(1'b0, 32'h310, 32'h0, 4'hF, 2, 1'b1, T - 1, 32'h89ABCDEF, 1'b0);

        // Randomized transactions.
        for (int n = 0; n < 30; n++) begin
            run_txn(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)),
                    $urandom_range(0, 3), ($urandom_range(0, 7) != 0), $urandom_range(0, T + 1),
                    $urandom, 1'($urandom_range(0, 1)));
        end

        // Reset while waiting for a response; the late response must be dropped.
        core_req_i  = 1'b1;
        core_we_i   = 1'b0;
        core_addr_i = 32'h400;
        bus_if.bus_req_ready_i = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst        = 1'b0;
        core_req_i = 1'b0;
        bus_if.bus_req_ready_i = 1'b0;
        bus_if.bus_rsp_valid_i = 1'b1;
        bus_if.bus_rsp_rdata_i = 32'h77778888;
        #1;
        check_val("post_rst_valid",  bus_if.bus_req_valid_o, 1'b0);
        check_val("post_rst_stall",  core_stall_o,  1'b0);
        check_val("post_rst_rvalid", core_rvalid_o, 1'b0);
        @(negedge clk);
        bus_if.bus_rsp_valid_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check_val("late_rsp_rvalid", core_rvalid_o, 1'b0);
            check_val("late_rsp_rdata",  core_rdata_o,  32'h0);
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
        $finish;
    end
endmodule
